// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared types and defaults for the MacArray input feeder.
//   - state_t      : feeder FSM states
//   - DEF_*        : default array geometry / bit widths shared with MacArray
//   - skew_depth() : extra delay stages for ifmap row r (row r lags row 0 by r cycles)
package mac_feeder_pkg;

  localparam int DEF_MAC_ROW        = 16;
  localparam int DEF_MAC_COL        = 16;
  localparam int DEF_IFMAP_BITWIDTH = 16;
  localparam int DEF_W_BITWIDTH     = 8;
  localparam int DEF_CNT_BITWIDTH   = 16;

  typedef enum logic [2:0] {
    IDLE,
    W_PRE,
    W_LOAD,
    IF_START,
    IF_FEED,
    DRAIN
  } state_t;

  // Row r of the array sees its ifmap element r cycles after row 0.
  function automatic int skew_depth(input int row);
    return row;
  endfunction

endpackage

// File: rtl/mac_feeder_skew_line.sv
// mac_skew_line: DEPTH-stage shift register used to skew one ifmap row.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   in       : {enable, data} from the feeder output register
//   out      : in delayed by DEPTH cycles; DEPTH=0 passes in straight through
module mac_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (DEPTH == 0) begin : g_wire
    // Row 0 uses the feeder output register directly.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out = in;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: the delay stages are cleared on reset (not left as plain storage)
        // so an abort mid-tile cannot leak stale enables into the array.
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= in;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign out = stage[DEPTH-1];
  end

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: transmitter for the MacArray input interface.
// Takes one weight tile (MAC_ROW row beats) and a stream of ifmap vectors from
// valid/ready sources and produces the MacArray protocol: w_prefetch pulse,
// weight-row beats, ifmap_start pulse, then per-row skewed ifmap enable/data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_in / reuse_w_in / ifmap_num_in   tile command, sampled in IDLE only
//   busy_out, done_out       tile in progress / one-cycle end-of-tile pulse
//   w_valid_in/w_ready_out/w_data_in              weight row source
//   ifmap_valid_in/ifmap_ready_out/ifmap_data_in  ifmap vector source
//   w_prefetch_out, w_enable_out, w_data_out      to MacArray weight port
//   ifmap_start_out, ifmap_enable_out, ifmap_data_out  to MacArray ifmap port
//
// Build option: define MAC_FEEDER_PERF_EN to add perf_stall_cnt_out[31:0], a
// saturating count of load/feed cycles with the active source's valid low.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int MAC_ROW        = DEF_MAC_ROW,
  parameter int MAC_COL        = DEF_MAC_COL,
  parameter int IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH,
  parameter int W_BITWIDTH     = DEF_W_BITWIDTH,
  parameter int CNT_BITWIDTH   = DEF_CNT_BITWIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_in,
  input  logic                              reuse_w_in,
  input  logic [CNT_BITWIDTH-1:0]           ifmap_num_in,
  output logic                              busy_out,
  output logic                              done_out,
  input  logic                              w_valid_in,
  output logic                              w_ready_out,
  input  logic [MAC_COL*W_BITWIDTH-1:0]     w_data_in,
  input  logic                              ifmap_valid_in,
  output logic                              ifmap_ready_out,
  input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_in,
  output logic                              w_prefetch_out,
  output logic                              w_enable_out,
  output logic [MAC_COL*W_BITWIDTH-1:0]     w_data_out,
  output logic                              ifmap_start_out,
  output logic [MAC_ROW-1:0]                ifmap_enable_out,
  output logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_out
`ifdef MAC_FEEDER_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cnt_out
`endif
);

  // DRAIN lasts MAC_ROW-1 cycles, so the design assumes MAC_ROW >= 2.
  localparam int WCW    = $clog2(MAC_ROW + 1);
  localparam int LANE_W = IFMAP_BITWIDTH + 1;
  localparam logic [WCW-1:0]          W_ONE      = WCW'(1);
  localparam logic [WCW-1:0]          W_LAST     = WCW'(MAC_ROW - 1);
  localparam logic [WCW-1:0]          DRAIN_LAST = WCW'(MAC_ROW - 2);
  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE    = CNT_BITWIDTH'(1);

  state_t                            state;
  logic [CNT_BITWIDTH-1:0]           ifmap_num_q;
  logic [CNT_BITWIDTH-1:0]           if_cnt;
  logic [WCW-1:0]                    w_cnt;
  logic [WCW-1:0]                    drain_cnt;
  logic                              w_fire;
  logic                              if_fire;
  logic                              if_en_q;
  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] if_data_q;

  assign w_ready_out     = (state == W_LOAD);
  assign ifmap_ready_out = (state == IF_FEED);
  assign w_fire          = w_valid_in & w_ready_out;
  assign if_fire         = ifmap_valid_in & ifmap_ready_out;

  // Control FSM. w_prefetch_out is raised on entry to W_PRE so it coincides
  // with that state; ifmap_start_out follows IF_START by one cycle so it lands
  // after the last weight beat has left the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      w_prefetch_out  <= 1'b0;
      ifmap_start_out <= 1'b0;
      ifmap_num_q     <= '0;
      if_cnt          <= '0;
      w_cnt           <= '0;
      drain_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge state regardless of statement order; later writes win.
      done_out        <= 1'b0;
      w_prefetch_out  <= 1'b0;
      ifmap_start_out <= (state == IF_START);
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out    <= 1'b1;
            ifmap_num_q <= ifmap_num_in;
            w_cnt       <= '0;
            if_cnt      <= '0;
            if (reuse_w_in) begin
              state <= IF_START;
            end else begin
              state          <= W_PRE;
              w_prefetch_out <= 1'b1;
            end
          end
        end
        W_PRE: state <= W_LOAD;
        W_LOAD: begin
          if (w_fire) begin
            w_cnt <= w_cnt + W_ONE;
            if (w_cnt == W_LAST) state <= IF_START;
          end
        end
        IF_START: begin
          drain_cnt <= '0;
          state     <= (ifmap_num_q == '0) ? DRAIN : IF_FEED;
        end
        IF_FEED: begin
          if (if_fire) begin
            if_cnt <= if_cnt + CNT_ONE;
            if (if_cnt == ifmap_num_q - CNT_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + W_ONE;
          if (drain_cnt == DRAIN_LAST) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register for weights and the shared first stage of every ifmap row.
  // Data registers load only on an accepted beat, so they hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable_out <= 1'b0;
      w_data_out   <= '0;
      if_en_q      <= 1'b0;
      if_data_q    <= '0;
    end else begin
      w_enable_out <= w_fire;
      if (w_fire) w_data_out <= w_data_in;
      if_en_q <= if_fire;
      if (if_fire) if_data_q <= ifmap_data_in;
    end
  end

  for (genvar r = 0; r < MAC_ROW; r++) begin : g_row
    logic [LANE_W-1:0] lane_out;

    mac_skew_line #(
      .DEPTH(skew_depth(r)),
      .WIDTH(LANE_W)
    ) u_skew (
      .clk(clk),
      .rst(rst),
      .in ({if_en_q, if_data_q[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]}),
      .out(lane_out)
    );

    assign ifmap_enable_out[r] = lane_out[LANE_W-1];
    assign ifmap_data_out[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] = lane_out[IFMAP_BITWIDTH-1:0];
  end

`ifdef MAC_FEEDER_PERF_EN
  logic stall;
  assign stall = ((state == W_LOAD) && !w_valid_in) ||
                 ((state == IF_FEED) && !ifmap_valid_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_out <= '0;
    end else if ((state == IDLE) && start_in) begin
      perf_stall_cnt_out <= '0;
    end else if (stall && (perf_stall_cnt_out != '1)) begin
      perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: self-checking bench for mac_feeder with a 4x4 array.
// Each tile is described at transaction level (weight rows with leading bubble
// counts, ifmap vectors with leading bubble counts); a reference model turns
// that into the expected per-cycle protocol trace, the bench replays the
// stimulus, records the outputs, and each test compares the trace.
// Cycle 0 of a tile is the cycle in which start_in is high.
module tb_mac_feeder;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int IW   = 16;
  localparam int WW   = 8;
  localparam int CW   = 16;
  localparam int WDW  = C * WW;
  localparam int IDW  = R * IW;
  localparam int MAXC = 256;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         pre;
    logic         wrdy;
    logic         wen;
    logic         start;
    logic         irdy;
    logic [R-1:0] ien;
  } ctl_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_in;
  logic           reuse_w_in;
  logic [CW-1:0]  ifmap_num_in;
  logic           busy_out;
  logic           done_out;
  logic           w_valid_in;
  logic           w_ready_out;
  logic [WDW-1:0] w_data_in;
  logic           ifmap_valid_in;
  logic           ifmap_ready_out;
  logic [IDW-1:0] ifmap_data_in;
  logic           w_prefetch_out;
  logic           w_enable_out;
  logic [WDW-1:0] w_data_out;
  logic           ifmap_start_out;
  logic [R-1:0]   ifmap_enable_out;
  logic [IDW-1:0] ifmap_data_out;
`ifdef MAC_FEEDER_PERF_EN
  logic [31:0]    perf_stall_cnt_out;
`endif

  mac_feeder #(
    .MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .CNT_BITWIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .start_in(start_in), .reuse_w_in(reuse_w_in), .ifmap_num_in(ifmap_num_in),
    .busy_out(busy_out), .done_out(done_out),
    .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_data_in(w_data_in),
    .ifmap_valid_in(ifmap_valid_in), .ifmap_ready_out(ifmap_ready_out),
    .ifmap_data_in(ifmap_data_in),
    .w_prefetch_out(w_prefetch_out), .w_enable_out(w_enable_out), .w_data_out(w_data_out),
    .ifmap_start_out(ifmap_start_out), .ifmap_enable_out(ifmap_enable_out),
    .ifmap_data_out(ifmap_data_out)
`ifdef MAC_FEEDER_PERF_EN
    , .perf_stall_cnt_out(perf_stall_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Tile description.
  int             w_gap  [R];
  logic [WDW-1:0] w_row  [R];
  int             if_gap [16];
  logic [IDW-1:0] if_vec [16];

  // Expected trace, stimulus table, observed trace.
  ctl_t           e_ctl [MAXC];
  logic [WDW-1:0] e_wd  [MAXC];
  logic [IW-1:0]  e_id  [MAXC][R];
  logic           d_start [MAXC];
  logic           d_reuse [MAXC];
  logic [CW-1:0]  d_num   [MAXC];
  logic           d_wv    [MAXC];
  logic [WDW-1:0] d_wd    [MAXC];
  logic           d_iv    [MAXC];
  logic [IDW-1:0] d_id    [MAXC];
  ctl_t           o_ctl [MAXC];
  logic [WDW-1:0] o_wd  [MAXC];
  logic [IDW-1:0] o_id  [MAXC];
  logic [31:0]    o_perf [MAXC];

  // Reference model: lays the tile out on a cycle timeline from the protocol
  // rules and fills both the stimulus and the expected outputs.
  task automatic build_tile(input bit reuse, input int num, output int done_c, output int stall);
    int t;
    int ifs;
    stall = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_ctl[c]   = '0;
      e_wd[c]    = '0;
      for (int r = 0; r < R; r++) e_id[c][r] = '0;
      d_start[c] = 1'b0;
      d_reuse[c] = 1'($urandom_range(0, 1));
      d_num[c]   = CW'($urandom_range(0, 20));
      d_wv[c]    = 1'($urandom_range(0, 1));
      d_wd[c]    = WDW'($urandom);
      d_iv[c]    = 1'($urandom_range(0, 1));
      d_id[c]    = IDW'({$urandom, $urandom});
    end
    d_start[0] = 1'b1;
    d_reuse[0] = reuse;
    d_num[0]   = CW'(num);
    t = 1;
    if (!reuse) begin
      e_ctl[1].pre = 1'b1;
      for (int i = 0; i < R; i++) begin
        for (int g = 0; g < w_gap[i]; g++) begin
          t++;
          e_ctl[t].wrdy = 1'b1;
          d_wv[t] = 1'b0;
          stall++;
        end
        t++;
        e_ctl[t].wrdy = 1'b1;
        d_wv[t] = 1'b1;
        d_wd[t] = w_row[i];
        e_ctl[t+1].wen = 1'b1;
        e_wd[t+1] = w_row[i];
      end
      t++;
    end
    ifs = t;
    e_ctl[ifs+1].start = 1'b1;
    for (int j = 0; j < num; j++) begin
      for (int g = 0; g < if_gap[j]; g++) begin
        t++;
        e_ctl[t].irdy = 1'b1;
        d_iv[t] = 1'b0;
        stall++;
      end
      t++;
      e_ctl[t].irdy = 1'b1;
      d_iv[t] = 1'b1;
      d_id[t] = if_vec[j];
      for (int r = 0; r < R; r++) begin
        e_ctl[t+1+r].ien[r] = 1'b1;
        e_id[t+1+r][r] = if_vec[j][r*IW +: IW];
      end
    end
    done_c = t + R;
    for (int c = 1; c < done_c; c++) begin
      e_ctl[c].busy = 1'b1;
      d_start[c] = ($urandom_range(0, 3) == 0);
    end
    e_ctl[done_c].done = 1'b1;
  endtask

  // Replays the stimulus table for n cycles; rst is pulsed in cycle 'abort'.
  task automatic run_tile(input int n, input int abort);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      rst            = (t == abort);
      start_in       = (abort >= 0 && t > abort) ? 1'b0 : d_start[t];
      reuse_w_in     = d_reuse[t];
      ifmap_num_in   = d_num[t];
      w_valid_in     = d_wv[t];
      w_data_in      = d_wd[t];
      ifmap_valid_in = d_iv[t];
      ifmap_data_in  = d_id[t];
      @(negedge clk);
      o_ctl[t] = {busy_out, done_out, w_prefetch_out, w_ready_out, w_enable_out,
                  ifmap_start_out, ifmap_ready_out, ifmap_enable_out};
      o_wd[t]  = w_data_out;
      o_id[t]  = ifmap_data_out;
`ifdef MAC_FEEDER_PERF_EN
      o_perf[t] = perf_stall_cnt_out;
`else
      o_perf[t] = '0;
`endif
    end
    start_in = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic random_tile_desc();
    for (int i = 0; i < R; i++) begin
      w_gap[i] = $urandom_range(0, 2);
      w_row[i] = WDW'($urandom);
    end
    for (int j = 0; j < 16; j++) begin
      if_gap[j] = $urandom_range(0, 2);
      if_vec[j] = IDW'({$urandom, $urandom});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b1; reuse_w_in = 1'b0; ifmap_num_in = CW'(5);
    w_valid_in = 1'b1; w_data_in = WDW'($urandom);
    ifmap_valid_in = 1'b1; ifmap_data_in = IDW'({$urandom, $urandom});
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_out, done_out, w_prefetch_out, w_ready_out, w_enable_out,
         ifmap_start_out, ifmap_ready_out, ifmap_enable_out} !== '0) begin
      bad++;
      $display("FAIL reset ctl: got %b exp 0", {busy_out, done_out, w_prefetch_out, w_ready_out,
               w_enable_out, ifmap_start_out, ifmap_ready_out, ifmap_enable_out});
    end
    total++;
    if (w_data_out !== '0) begin bad++; $display("FAIL reset w_data: got %h exp 0", w_data_out); end
    total++;
    if (ifmap_data_out !== '0) begin bad++; $display("FAIL reset ifmap_data: got %h exp 0", ifmap_data_out); end
`ifdef MAC_FEEDER_PERF_EN
    total++;
    if (perf_stall_cnt_out !== 32'd0) begin bad++; $display("FAIL reset perf: got %0d exp 0", perf_stall_cnt_out); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0; start_in = 1'b0; w_valid_in = 1'b0; ifmap_valid_in = 1'b0;
  endtask

  // Contiguous weight rows 0x04..0x01 then three contiguous vectors 0x10*n+r.
  task automatic test_weight_skew();
    int done_c, stall;
    for (int i = 0; i < R; i++) begin
      w_gap[i] = 0;
      w_row[i] = {C{WW'(R - i)}};
    end
    for (int n = 0; n < 3; n++) begin
      if_gap[n] = 0;
      for (int r = 0; r < R; r++) if_vec[n][r*IW +: IW] = IW'(16 * n + r);
    end
    build_tile(1'b0, 3, done_c, stall);
    run_tile(done_c + 2, -1);
    for (int t = 0; t < done_c + 2; t++) begin
      total++;
      if (o_ctl[t] !== e_ctl[t]) begin
        bad++; $display("FAIL wskew ctl cycle %0d: got %b exp %b", t, o_ctl[t], e_ctl[t]);
      end
      if (e_ctl[t].wen) begin
        total++;
        if (o_wd[t] !== e_wd[t]) begin
          bad++; $display("FAIL wskew w_data cycle %0d: got %h exp %h", t, o_wd[t], e_wd[t]);
        end
      end
      for (int r = 0; r < R; r++)
        if (e_ctl[t].ien[r]) begin
          total++;
          if (o_id[t][r*IW +: IW] !== e_id[t][r]) begin
            bad++; $display("FAIL wskew row%0d data cycle %0d: got %h exp %h", r, t, o_id[t][r*IW +: IW], e_id[t][r]);
          end
        end
    end
  endtask

  // Ifmap valid 1,0,1,1 and a 2-cycle gap before weight row 2.
  task automatic test_bubbles();
    int done_c, stall;
    random_tile_desc();
    w_gap[0] = 0; w_gap[1] = 0; w_gap[2] = 2; w_gap[3] = 0;
    if_gap[0] = 0; if_gap[1] = 1; if_gap[2] = 0;
    build_tile(1'b0, 3, done_c, stall);
    run_tile(done_c + 2, -1);
    for (int t = 0; t < done_c + 2; t++) begin
      total++;
      if (o_ctl[t] !== e_ctl[t]) begin
        bad++; $display("FAIL bubbles ctl cycle %0d: got %b exp %b", t, o_ctl[t], e_ctl[t]);
      end
      if (e_ctl[t].wen) begin
        total++;
        if (o_wd[t] !== e_wd[t]) begin
          bad++; $display("FAIL bubbles w_data cycle %0d: got %h exp %h", t, o_wd[t], e_wd[t]);
        end
      end
      for (int r = 0; r < R; r++)
        if (e_ctl[t].ien[r]) begin
          total++;
          if (o_id[t][r*IW +: IW] !== e_id[t][r]) begin
            bad++; $display("FAIL bubbles row%0d data cycle %0d: got %h exp %h", r, t, o_id[t][r*IW +: IW], e_id[t][r]);
          end
        end
    end
  endtask

  // Weight reuse with an empty ifmap stream: start pulse, drain, done only.
  task automatic test_reuse_zero();
    int done_c, stall;
    random_tile_desc();
    build_tile(1'b1, 0, done_c, stall);
    run_tile(done_c + 2, -1);
    for (int t = 0; t < done_c + 2; t++) begin
      total++;
      if (o_ctl[t] !== e_ctl[t]) begin
        bad++; $display("FAIL reuse0 ctl cycle %0d: got %b exp %b", t, o_ctl[t], e_ctl[t]);
      end
    end
  endtask

  // Reset while rows 0..2 are enabled, then a clean tile.
  task automatic test_mid_reset();
    int done_c, stall, n, abort;
    for (int k = 0; k < 2; k++) begin
      random_tile_desc();
      if (k == 0) begin
        for (int j = 0; j < 6; j++) if_gap[j] = 0;
        build_tile(1'b1, 6, done_c, stall);
        abort = 5;
        n = abort + 2;
        e_ctl[abort+1] = '0;
      end else begin
        build_tile(1'b0, 4, done_c, stall);
        abort = -1;
        n = done_c + 2;
      end
      run_tile(n, abort);
      for (int t = 0; t < n; t++) begin
        total++;
        if (o_ctl[t] !== e_ctl[t]) begin
          bad++; $display("FAIL midrst%0d ctl cycle %0d: got %b exp %b", k, t, o_ctl[t], e_ctl[t]);
        end
        if (e_ctl[t].wen) begin
          total++;
          if (o_wd[t] !== e_wd[t]) begin
            bad++; $display("FAIL midrst%0d w_data cycle %0d: got %h exp %h", k, t, o_wd[t], e_wd[t]);
          end
        end
        for (int r = 0; r < R; r++)
          if (e_ctl[t].ien[r]) begin
            total++;
            if (o_id[t][r*IW +: IW] !== e_id[t][r]) begin
              bad++; $display("FAIL midrst%0d row%0d data cycle %0d: got %h exp %h", k, r, t, o_id[t][r*IW +: IW], e_id[t][r]);
            end
          end
      end
    end
  endtask

  task automatic test_random();
    int done_c, stall, num;
    bit reuse;
    for (int k = 0; k < 6; k++) begin
      random_tile_desc();
      reuse = 1'($urandom_range(0, 1));
      num   = $urandom_range(0, 8);
      build_tile(reuse, num, done_c, stall);
      run_tile(done_c + 2, -1);
      for (int t = 0; t < done_c + 2; t++) begin
        total++;
        if (o_ctl[t] !== e_ctl[t]) begin
          bad++; $display("FAIL rand%0d ctl cycle %0d: got %b exp %b", k, t, o_ctl[t], e_ctl[t]);
        end
        if (e_ctl[t].wen) begin
          total++;
          if (o_wd[t] !== e_wd[t]) begin
            bad++; $display("FAIL rand%0d w_data cycle %0d: got %h exp %h", k, t, o_wd[t], e_wd[t]);
          end
        end
        for (int r = 0; r < R; r++)
          if (e_ctl[t].ien[r]) begin
            total++;
            if (o_id[t][r*IW +: IW] !== e_id[t][r]) begin
              bad++; $display("FAIL rand%0d row%0d data cycle %0d: got %h exp %h", k, r, t, o_id[t][r*IW +: IW], e_id[t][r]);
            end
          end
      end
    end
  endtask

`ifdef MAC_FEEDER_PERF_EN
  // Five stall cycles (3 in weight load, 2 in ifmap feed), then a new start clears.
  task automatic test_perf();
    int done_c, stall;
    random_tile_desc();
    w_gap[0] = 0; w_gap[1] = 2; w_gap[2] = 0; w_gap[3] = 1;
    if_gap[0] = 0; if_gap[1] = 1; if_gap[2] = 1;
    build_tile(1'b0, 3, done_c, stall);
    run_tile(done_c + 2, -1);
    total++;
    if (o_perf[1] !== 32'd0) begin bad++; $display("FAIL perf clear@start: got %0d exp 0", o_perf[1]); end
    total++;
    if (o_perf[done_c] !== 32'(stall)) begin bad++; $display("FAIL perf at done: got %0d exp %0d", o_perf[done_c], stall); end
    random_tile_desc();
    build_tile(1'b1, 0, done_c, stall);
    run_tile(done_c + 2, -1);
    total++;
    if (o_perf[0] !== 32'd5) begin bad++; $display("FAIL perf held idle: got %0d exp 5", o_perf[0]); end
    total++;
    if (o_perf[1] !== 32'd0) begin bad++; $display("FAIL perf cleared: got %0d exp 0", o_perf[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_weight_skew();
    test_bubbles();
    test_reuse_zero();
    test_mid_reset();
    test_random();
`ifdef MAC_FEEDER_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Hardware transmitter for the MacArray input interface.
- Accepts one weight tile and an ifmap vector stream from upstream valid/ready sources.
- Generates the MacArray input protocol: w_prefetch pulse, MAC_ROW weight-row beats, ifmap_start pulse, then per-row skewed ifmap enable/data (row r delayed r cycles).
- Sits between the on-chip buffers and MacArray; replaces the bench-driven stimulus in the integrated design.

Parameters:
- MAC_ROW, 16, array rows = ifmap lanes = weight rows per tile
- MAC_COL, 16, array columns = weights per row beat
- IFMAP_BITWIDTH, 16, ifmap element width
- W_BITWIDTH, 8, weight element width
- CNT_BITWIDTH, 16, width of ifmap vector count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_in  in  1  begin a tile; sampled only in IDLE
- reuse_w_in  in  1  sampled with start_in; 1 = skip weight phase
- ifmap_num_in  in  CNT_BITWIDTH  ifmap vectors this tile; sampled with start_in
- busy_out  out  1  high from start accept until done
- done_out  out  1  one-cycle pulse at tile end
- w_valid_in  in  1  weight row beat valid
- w_ready_out  out  1  weight row beat ready
- w_data_in  in  MAC_COL*W_BITWIDTH  one weight row, upstream order row MAC_ROW-1 first
- ifmap_valid_in  in  1  ifmap vector valid
- ifmap_ready_out  out  1  ifmap vector ready
- ifmap_data_in  in  MAC_ROW*IFMAP_BITWIDTH  one element per row, same index n
- w_prefetch_out  out  1  to MacArray w_prefetch_in
- w_enable_out  out  1  to MacArray w_enable_in
- w_data_out  out  MAC_COL*W_BITWIDTH  to MacArray w_data_in
- ifmap_start_out  out  1  to MacArray ifmap_start_in
- ifmap_enable_out  out  MAC_ROW  to MacArray ifmap_enable_in
- ifmap_data_out  out  MAC_ROW*IFMAP_BITWIDTH  to MacArray ifmap_data_in

Behaviour:
- All array-side outputs and busy_out/done_out are registered. On rst, every output is 0, all skew delay lines are cleared, and the FSM returns to IDLE on the next edge, including mid-tile.
- FSM states: IDLE, W_PRE, W_LOAD, IF_START, IF_FEED, DRAIN.
  - IDLE: start_in=1 latches ifmap_num_in and reuse_w_in and sets busy. Next state is W_PRE, or IF_START if reuse_w_in=1. start_in outside IDLE is ignored.
  - W_PRE: w_prefetch_out=1 for exactly one cycle, then W_LOAD.
  - W_LOAD: w_ready_out=1 (combinational from state). Each accepted beat appears on w_enable_out=1/w_data_out on the following cycle. A cycle without valid gives w_enable_out=0 (bubble; the array shifts only on enable). After MAC_ROW accepted beats, go to IF_START.
  - IF_START: ifmap_start_out=1 for exactly one cycle, then IF_FEED; if the latched count is 0, go to DRAIN.
  - IF_FEED: ifmap_ready_out=1. An accepted beat at edge E drives row r enable=1 and data=element r at cycle E+1+r. Bubbles propagate per row with the same skew. After ifmap_num accepted beats, go to DRAIN.
  - DRAIN: lasts MAC_ROW-1 cycles so the last beat exits row MAC_ROW-1. Then done_out=1 for one cycle, busy_out=0, and the FSM returns to IDLE.
- Ready is never asserted outside W_LOAD/IF_FEED. A beat is accepted only on valid&ready.
- ifmap_data_out holds its last value when enable is low. Data is don't-care; the bench checks enable-qualified data only.
- Beat counters are CNT_BITWIDTH wide, compared to the latched count, with no wrap. The weight counter uses clog2(MAC_ROW+1) bits.
- Skew delay lines: row r is an r-stage shift register of {enable, data}; row 0 is the output register only.

Optional Feature:
- MAC_FEEDER_PERF_EN defined: adds output perf_stall_cnt_out[31:0].
  - Counts cycles in W_LOAD or IF_FEED with valid low.
  - Cleared on rst and on start accept; saturates at all-ones.
- Undefined: port and counter absent; remaining behaviour identical.

Decomposition:
- Package mac_feeder_pkg:
  - state enum typedef
  - localparams for the default MAC_ROW/MAC_COL/bitwidths shared with MacArray
  - skew-depth function returning r for row r
- Sub-module mac_skew_line (params DEPTH, WIDTH; clk, rst, in, out):
  - instantiated per row by generate
  - DEPTH=0 is a wire-through of the output register.

Test Plan (bench MAC_ROW=MAC_COL=4):
1. Weight load: start_in at cycle 0 with reuse_w=0, then 4 contiguous rows 0x04..,0x03..,0x02..,0x01.. -> w_prefetch_out high cycle 1 only; w_enable_out high 4 cycles in the same row order; ifmap_start_out high the cycle after.
2. Skew: ifmap_num=3, contiguous vectors {row r = 0x10*n+r} -> row r enable high cycles E+1+r..E+3+r with data 0x10*n+r; done_out pulses 3 cycles after the last row-0 beat.
3. Bubbles: ifmap_valid pattern 1,0,1,1 with ifmap_num=3 -> every row shows enable pattern 1,0,1,1 shifted by r; weights with a 2-cycle valid gap give a matching w_enable_out gap.
4. reuse_w_in=1 with ifmap_num=0 -> no w_prefetch/w_enable activity; ifmap_start one cycle; done_out after 3 drain cycles; no ifmap_enable ever.
5. rst asserted mid IF_FEED with rows 0..2 enabled -> next cycle all enables/ready/busy are 0 and the FSM is in IDLE; a following start_in runs a clean tile.
6. MAC_FEEDER_PERF_EN: 5 stall cycles across both phases -> perf_stall_cnt_out=5 at done; a new start clears it to 0.
